// File: rtl/upsp_axis_sender_pkg.sv
// Shared constants for the up-sampling output path (common with upsp_outbuf).
package upsp_axis_sender_pkg;

    localparam int PIXEL_WIDTH        = 24;
    localparam int DEF_DATA_WIDTH     = 96;
    localparam int DEF_DST_IMG_WIDTH  = 4096;
    localparam int DEF_DST_IMG_HEIGHT = 2160;
    localparam int DEF_QDEPTH         = 3;

    typedef struct packed {
        logic last;
        logic user;
    } axis_side_t;

    function automatic int pix_per_beat(input int data_width);
        return data_width / PIXEL_WIDTH;
    endfunction

endpackage

// File: rtl/upsp_axis_queue.sv
// In-order register FIFO; entry 0 is the head and drives the stream directly from a register.
module upsp_axis_queue #(
    parameter int  DATA_WIDTH = 96,
    parameter int  QDEPTH     = 3,
    localparam int CW         = $clog2(QDEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] head,
    output logic                  head_valid,
    output logic [CW-1:0]         count
);

    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [DATA_WIDTH-1:0] mem_r [QDEPTH];
    logic [DATA_WIDTH-1:0] mem_s [QDEPTH];
    logic [CW-1:0]         count_r;
    logic [CW-1:0]         count_s;
    logic [CW-1:0]         wr_idx_s;
    logic                  valid_r;
    logic                  do_pop_s;

    // Next state: shift toward the head on pop, then write into the first free slot
    always_comb begin
        mem_s    = mem_r;
        do_pop_s = pop & valid_r;
        if (do_pop_s) begin
            for (int i = 0; i < QDEPTH - 1; i++) begin
                mem_s[i] = mem_r[i + 1];
            end
            mem_s[QDEPTH - 1] = {DATA_WIDTH{1'b0}};
            wr_idx_s          = count_r - CNT_ONE;
        end else begin
            wr_idx_s = count_r;
        end
        if (push) begin
            for (int i = 0; i < QDEPTH; i++) begin
                mem_s[i] = (CW'(i) == wr_idx_s) ? wdata : mem_s[i];
            end
            count_s = wr_idx_s + CNT_ONE;
        end else begin
            count_s = wr_idx_s;
        end
    end

    // Storage, occupancy and head-valid registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < QDEPTH; i++) begin
                mem_r[i] <= {DATA_WIDTH{1'b0}};
            end
            count_r <= {CW{1'b0}};
            valid_r <= 1'b0;
        end else begin
            mem_r   <= mem_s;
            count_r <= count_s;
            valid_r <= (count_s != {CW{1'b0}});
        end
    end

    assign head       = mem_r[0];
    assign head_valid = valid_r;
    assign count      = count_r;

endmodule

// File: rtl/upsp_axis_sender.sv
// Drains outbuf words into an AXI4-Stream video master (tuser=SOF, tlast=EOL) and pulses
// frame_done once the final beat of the destination frame has been accepted.
import upsp_axis_sender_pkg::*;

module upsp_axis_sender #(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int DST_IMG_WIDTH  = DEF_DST_IMG_WIDTH,
    parameter int DST_IMG_HEIGHT = DEF_DST_IMG_HEIGHT,
    parameter int QDEPTH         = DEF_QDEPTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  buf_empty,
    input  logic [DATA_WIDTH-1:0] buf_rdata,
    output logic                  buf_rd,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    output logic                  frame_done
);

    localparam int                PPB      = pix_per_beat(DATA_WIDTH);
    localparam int                COL_W    = $clog2(DST_IMG_WIDTH);
    localparam int                ROW_W    = $clog2(DST_IMG_HEIGHT);
    localparam int                CW       = $clog2(QDEPTH + 1);
    localparam logic [COL_W-1:0]  COL_LAST = COL_W'(DST_IMG_WIDTH - PPB);
    localparam logic [COL_W-1:0]  COL_STEP = COL_W'(PPB);
    localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(DST_IMG_HEIGHT - 1);
    localparam logic [ROW_W-1:0]  ROW_ONE  = ROW_W'(1);
    localparam logic [CW:0]       OCC_MAX  = (CW + 1)'(QDEPTH);

    logic                  inflight_r;
    logic [COL_W-1:0]      col_r;
    logic [COL_W-1:0]      col_s;
    logic [ROW_W-1:0]      row_r;
    logic [ROW_W-1:0]      row_s;
    axis_side_t            side_r;
    axis_side_t            side_s;
    logic                  frame_done_r;
    logic                  frame_end_s;
    logic                  rd_s;
    logic                  hs_s;
    logic [CW:0]           occ_s;
    logic [CW-1:0]         q_count_s;
    logic [DATA_WIDTH-1:0] q_data_s;
    logic                  q_valid_s;

    upsp_axis_queue #(
        .DATA_WIDTH (DATA_WIDTH),
        .QDEPTH     (QDEPTH)
    ) u_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (inflight_r),
        .pop        (hs_s),
        .wdata      (buf_rdata),
        .head       (q_data_s),
        .head_valid (q_valid_s),
        .count      (q_count_s)
    );

    // Read issue reserves a slot for the word in flight; the rst_n term keeps buf_rd low during reset
    always_comb begin
        occ_s = {1'b0, q_count_s} + {{CW{1'b0}}, inflight_r};
        rd_s  = rst_n & ~buf_empty & (occ_s < OCC_MAX);
        hs_s  = q_valid_s & m_axis_tready;
    end

    // Outbuf returns data one clock after the pop, so push follows buf_rd by a cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_r <= 1'b0;
        end else begin
            inflight_r <= rd_s;
        end
    end

    // Position advances on handshake only; sideband is precomputed for the next head beat
    always_comb begin
        row_s       = row_r;
        frame_end_s = hs_s & (col_r == COL_LAST) & (row_r == ROW_LAST);
        if (hs_s) begin
            if (col_r == COL_LAST) begin
                col_s = {COL_W{1'b0}};
                if (row_r == ROW_LAST) begin
                    row_s = {ROW_W{1'b0}};
                end else begin
                    row_s = row_r + ROW_ONE;
                end
            end else begin
                col_s = col_r + COL_STEP;
            end
        end else begin
            col_s = col_r;
        end
        side_s.last = (col_s == COL_LAST);
        side_s.user = (col_s == {COL_W{1'b0}}) & (row_s == {ROW_W{1'b0}});
    end

    // Position, sideband and frame_done registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_r        <= {COL_W{1'b0}};
            row_r        <= {ROW_W{1'b0}};
            side_r       <= '{last: 1'b0, user: 1'b0};
            frame_done_r <= 1'b0;
        end else begin
            col_r        <= col_s;
            row_r        <= row_s;
            side_r       <= side_s;
            frame_done_r <= frame_end_s;
        end
    end

    assign buf_rd        = rd_s;
    assign m_axis_tvalid = q_valid_s;
    assign m_axis_tdata  = q_data_s;
    assign m_axis_tlast  = side_r.last;
    assign m_axis_tuser  = side_r.user;
    assign frame_done    = frame_done_r;

endmodule

// File: tb/tb_upsp_axis_sender.sv
// Scoreboard bench: an outbuf model feeds words, expected beats are queued at load time and a
// monitor compares every accepted beat, frame_done pulse and queue occupancy step.
module tb_upsp_axis_sender;

    localparam int DW  = 96;
    localparam int W   = 16;
    localparam int H   = 4;
    localparam int QD  = 3;
    localparam int BPL = W / 4;
    localparam int BPF = BPL * H;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          buf_empty = 1'b1;
    logic [DW-1:0] buf_rdata = '0;
    logic          buf_rd;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b0;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tlast;
    logic          m_axis_tuser;
    logic          frame_done;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        logic          user;
        logic          fend;
    } beat_t;

    logic [DW-1:0] src_q[$];
    beat_t         exp_q[$];
    int            checks = 0;
    int            errors = 0;
    int            beat_idx = 0;
    int            word_seq = 0;
    int            rd_total = 0;
    int            hs_total = 0;
    int            fd_total = 0;
    int            fd_base = 0;
    int            mcyc = 0;
    int            first_hs = -1;
    int            last_hs = -1;
    bit            pend_v = 1'b0;
    logic [DW-1:0] pend_w;
    bit            rand_empty = 1'b0;
    bit            rand_ready = 1'b0;
    bit            ready_level = 1'b0;
    bit            saw_pp2 = 1'b0;

    // monitor state
    bit            stall_v = 1'b0;
    bit            fd_due = 1'b0;
    bit            cnt_v = 1'b0;
    bit            push_prev, pop_prev, hs;
    int            cnt_prev, cur_cnt;
    logic [DW-1:0] held_d;
    logic          held_l, held_u;
    beat_t         e;

    upsp_axis_sender #(
        .DATA_WIDTH     (DW),
        .DST_IMG_WIDTH  (W),
        .DST_IMG_HEIGHT (H),
        .QDEPTH         (QD)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .buf_empty     (buf_empty),
        .buf_rdata     (buf_rdata),
        .buf_rd        (buf_rd),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .frame_done    (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] mkword(input int k);
        logic [31:0] a;
        a = 32'(k);
        return {a ^ 32'hA5A5_0000, ~a, a + 32'h0000_0100};
    endfunction

    task automatic load(input int n);
        for (int k = 0; k < n; k++) begin
            beat_t b;
            b.data = mkword(word_seq);
            b.last = ((beat_idx % BPL) == BPL - 1);
            b.user = ((beat_idx % BPF) == 0);
            b.fend = ((beat_idx % BPF) == BPF - 1);
            word_seq++;
            beat_idx++;
            src_q.push_back(b.data);
            exp_q.push_back(b);
        end
    endtask

    task automatic drain(input string nm, input int limit);
        int n = 0;
        while ((exp_q.size() != 0 || src_q.size() != 0) && n < limit) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        #2;
        chk(nm, exp_q.size(), 0);
    endtask

    task automatic wait_hs(input int target, input int limit);
        int n = 0;
        while (hs_total < target && n < limit) begin
            @(negedge clk);
            #2;
            n++;
        end
        chk("wait_hs_reached", (hs_total >= target), 1'b1);
    endtask

    // Outbuf model: the word popped in one cycle is on buf_rdata during the next
    always @(negedge clk) begin
        if (pend_v) buf_rdata = pend_w;
        pend_v = 1'b0;
        buf_empty = (src_q.size() == 0) || (rand_empty && ($urandom_range(0, 2) == 0));
        m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : ready_level;
        #1;
        if (buf_empty) chk("rd_while_empty", buf_rd, 1'b0);
        if (rst_n && buf_rd && src_q.size() != 0) begin
            rd_total++;
            pend_w = src_q.pop_front();
            pend_v = 1'b1;
        end
    end

    // Monitor: scoreboard compare on each handshake, AXIS hold rules, frame_done, occupancy
    always @(negedge clk) begin
        #1;
        mcyc++;
        if (!rst_n) begin
            stall_v = 1'b0;
            fd_due  = 1'b0;
            cnt_v   = 1'b0;
        end else begin
            hs = m_axis_tvalid && m_axis_tready;
            if (fd_due || frame_done) chk("frame_done_pulse", frame_done, fd_due);
            if (frame_done) fd_total++;
            if (stall_v) begin
                chk("hold_tvalid", m_axis_tvalid, 1'b1);
                chk("hold_tdata", m_axis_tdata, held_d);
                chk("hold_tlast", m_axis_tlast, held_l);
                chk("hold_tuser", m_axis_tuser, held_u);
            end
            cur_cnt = int'(dut.u_queue.count_r);
            if (cnt_v) begin
                chk("q_count", cur_cnt, cnt_prev + int'(push_prev) - int'(pop_prev));
                if (cnt_prev == 2 && push_prev && pop_prev) saw_pp2 = 1'b1;
            end
            cnt_prev  = cur_cnt;
            push_prev = dut.inflight_r;
            pop_prev  = hs;
            cnt_v     = 1'b1;
            fd_due    = 1'b0;
            if (hs) begin
                hs_total++;
                if (first_hs < 0) first_hs = mcyc;
                last_hs = mcyc;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_beat: actual data %0h required no beat", m_axis_tdata);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_tdata", m_axis_tdata, e.data);
                    chk("beat_tlast", m_axis_tlast, e.last);
                    chk("beat_tuser", m_axis_tuser, e.user);
                    fd_due = e.fend;
                end
            end
            stall_v = m_axis_tvalid && !m_axis_tready;
            held_d  = m_axis_tdata;
            held_l  = m_axis_tlast;
            held_u  = m_axis_tuser;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // reset state, with data already waiting in the outbuf
        load(16);
        ready_level = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        chk("rst_buf_rd", buf_rd, 1'b0);
        chk("rst_tvalid", m_axis_tvalid, 1'b0);
        chk("rst_tdata", m_axis_tdata, 96'h0);
        chk("rst_tlast", m_axis_tlast, 1'b0);
        chk("rst_tuser", m_axis_tuser, 1'b0);
        chk("rst_frame_done", frame_done, 1'b0);

        // 1: one frame at full rate
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #2;
        chk("t1_tvalid_1clk", m_axis_tvalid, 1'b0);
        @(negedge clk); #2;
        chk("t1_tvalid_2clk", m_axis_tvalid, 1'b1);
        drain("t1_drain", 100);
        chk("t1_beats", hs_total, 16);
        chk("t1_consecutive", last_hs - first_hs, 15);
        chk("t1_frame_done", fd_total, 1);

        // 2: stall mid-line for 10 clocks
        load(16);
        wait_hs(18, 100);
        ready_level = 1'b0;
        repeat (10) @(negedge clk);
        #2;
        chk("t2_rd_idle", buf_rd, 1'b0);
        chk("t2_outstanding", rd_total - hs_total, QD);
        ready_level = 1'b1;
        drain("t2_drain", 200);
        chk("t2_beats", hs_total, 32);
        chk("t2_frame_done", fd_total, 2);

        // 3: random buf_empty and tready
        rand_empty = 1'b1;
        rand_ready = 1'b1;
        load(16);
        drain("t3_drain", 2000);
        rand_empty = 1'b0;
        rand_ready = 1'b0;
        chk("t3_beats", hs_total, 48);
        chk("t3_frame_done", fd_total, 3);

        // 4: two frames back to back
        load(32);
        drain("t4_drain", 300);
        chk("t4_beats", hs_total, 80);
        chk("t4_frame_done", fd_total, 5);

        // 6: short stall so a push and a pop meet with two entries queued
        ready_level = 1'b0;
        load(8);
        repeat (3) @(negedge clk);
        #2;
        ready_level = 1'b1;
        drain("t6_drain", 200);
        chk("t6_beats", hs_total, 88);
        chk("t6_push_pop_at_2", saw_pp2, 1'b1);

        // 5: asynchronous reset with the queue full after six beats
        load(16);
        wait_hs(94, 100);
        ready_level = 1'b0;
        repeat (6) @(negedge clk);
        #2;
        chk("t5_q_full", dut.u_queue.count_r, QD);
        rst_n = 1'b0;
        src_q.delete();
        exp_q.delete();
        pend_v   = 1'b0;
        beat_idx = 0;
        rd_total = 0;
        hs_total = 0;
        #1;
        chk("t5_buf_rd", buf_rd, 1'b0);
        chk("t5_tvalid", m_axis_tvalid, 1'b0);
        chk("t5_tdata", m_axis_tdata, 96'h0);
        chk("t5_tlast", m_axis_tlast, 1'b0);
        chk("t5_tuser", m_axis_tuser, 1'b0);
        chk("t5_frame_done", frame_done, 1'b0);
        fd_base = fd_total;
        load(16);
        ready_level = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        drain("t5_drain", 100);
        chk("t5_beats", hs_total, 16);
        chk("t5_frame_done_after", fd_total, fd_base + 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
